// File: rtl/pwm_output_stage_if.sv
// Configuration and drive bundle between the SPI register file and the PWM output stage.
// The register file is the master; the output stage is the slave.
interface pwm_output_stage_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  uo_out, uio_out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output uo_out, uio_out, period_start
  );
endinterface

// File: rtl/pwm_output_stage.sv
// Drives 16 outputs low, static high or from a shared 8-bit PWM waveform.
// The duty cycle is shadowed at the period wrap so that waveform changes never glitch.
module pwm_output_stage #(
  parameter int CLK_DIV = 13
) (
  input logic              clk,
  input logic              rst_n,
  pwm_output_stage_if.slave bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 4096) begin : g_bad_div
      $error("pwm_output_stage: CLK_DIV must be in 1..4096");
    end
  endgenerate

  logic [PRE_W-1:0] pre;
  logic [7:0]       cnt;
  logic [7:0]       duty_sh;
  logic             wrap_d;
  logic [15:0]      out_q;
  logic             period_start_q;

  logic        tick;
  logic        wrap;
  logic        pwm_level;
  logic [15:0] out_en;
  logic [15:0] pwm_en;
  logic [15:0] out_next;

  assign tick      = (pre == PRE_MAX);
  assign wrap      = tick && (cnt == 8'hFF);
  assign pwm_level = (duty_sh == 8'hFF) | (cnt < duty_sh);

  assign out_en   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign pwm_en   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  assign out_next = out_en & ((pwm_en & {16{pwm_level}}) | ~pwm_en);

  // wrap_d delays the period marker so period_start lines up with the first
  // output cycle that reflects the new period's count and duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre            <= '0;
      cnt            <= '0;
      duty_sh        <= '0;
      wrap_d         <= 1'b0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        cnt <= cnt + 8'd1;
      end
      if (wrap) begin
        duty_sh <= bus.pwm_duty_cycle;
      end
      wrap_d         <= wrap;
      period_start_q <= wrap_d;
      out_q          <= out_next;
    end
  end

  assign bus.uo_out       = out_q[7:0];
  assign bus.uio_out      = out_q[15:8];
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: two instances (CLK_DIV 13 and 1) checked every cycle against
// an arithmetic reference model, plus directed period, duty-change and reset measurements.
module tb_pwm_output_stage;

  localparam int DIV_A = 13;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pwm_output_stage_if busA ();
  pwm_output_stage_if busB ();

  pwm_output_stage #(.CLK_DIV(DIV_A)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  pwm_output_stage #(.CLK_DIV(DIV_B)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  int errorCount = 0;
  int checkCount = 0;

  logic [7:0] cfgOutLo = 8'h00, cfgOutHi = 8'h00, cfgPwmLo = 8'h00, cfgPwmHi = 8'h00, cfgDuty = 8'h00;

  int         divOf[2] = '{DIV_A, DIV_B};
  int         edges[2];
  logic [7:0] dutyRef[2];
  bit         wrapPend[2];
  logic [16:0] expVec[2];
  bit         scoreOn = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] outLo, input logic [7:0] outHi,
                               input logic [7:0] pwmLo, input logic [7:0] pwmHi,
                               input logic [7:0] duty);
    cfgOutLo = outLo; cfgOutHi = outHi; cfgPwmLo = pwmLo; cfgPwmHi = pwmHi; cfgDuty = duty;
    busA.en_reg_out_7_0 = outLo; busA.en_reg_out_15_8 = outHi;
    busA.en_reg_pwm_7_0 = pwmLo; busA.en_reg_pwm_15_8 = pwmHi; busA.pwm_duty_cycle = duty;
    busB.en_reg_out_7_0 = outLo; busB.en_reg_out_15_8 = outHi;
    busB.en_reg_pwm_7_0 = pwmLo; busB.en_reg_pwm_15_8 = pwmHi; busB.pwm_duty_cycle = duty;
  endtask

  // Reference: position in the period is edges mod (256*div); the duty in force is the
  // value captured on the last edge that closed a period.
  task automatic modelStep(input int j);
    int periodLen, pos, cntNow;
    bit level;
    logic [15:0] en, pe, outs;
    periodLen = 256 * divOf[j];
    pos       = edges[j] % periodLen;
    cntNow    = pos / divOf[j];
    level     = (dutyRef[j] == 8'hFF) || (cntNow < int'(dutyRef[j]));
    en        = {cfgOutHi, cfgOutLo};
    pe        = {cfgPwmHi, cfgPwmLo};
    for (int i = 0; i < 16; i++) begin
      outs[i] = en[i] ? (pe[i] ? level : 1'b1) : 1'b0;
    end
    expVec[j]   = {wrapPend[j], outs};
    wrapPend[j] = (pos == periodLen - 1);
    if (wrapPend[j]) dutyRef[j] = cfgDuty;
    edges[j]++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int j = 0; j < 2; j++) begin
        if (!rst_n) begin
          edges[j] = 0; dutyRef[j] = 8'h00; wrapPend[j] = 1'b0; expVec[j] = '0;
        end else begin
          modelStep(j);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (scoreOn) begin
        checkOutput("A_cycle", {15'd0, busA.period_start, busA.uio_out, busA.uo_out}, {15'd0, expVec[0]});
        checkOutput("B_cycle", {15'd0, busB.period_start, busB.uio_out, busB.uo_out}, {15'd0, expVec[1]});
      end
    end
  end

  function automatic logic [15:0] outsOf(input int sel);
    return (sel == 0) ? {busA.uio_out, busA.uo_out} : {busB.uio_out, busB.uo_out};
  endfunction

  function automatic logic pulseOf(input int sel);
    return (sel == 0) ? busA.period_start : busB.period_start;
  endfunction

  // Starting at a period_start cycle, walk to the next one, gathering output statistics.
  task automatic runPeriod(input int sel, input int changeAt, input logic [7:0] newDuty,
                           output int cycles, output int highs, output int allHigh, output int allLow);
    logic [15:0] v;
    cycles = 0; highs = 0; allHigh = 0; allLow = 0;
    do begin
      v = outsOf(sel);
      if (v[0]) highs++;
      if (v == 16'hFFFF) allHigh++;
      if (v == 16'h0000) allLow++;
      if (cycles == changeAt) applyStimulus(cfgOutLo, cfgOutHi, cfgPwmLo, cfgPwmHi, newDuty);
      cycles++;
      @(negedge clk);
    end while (!pulseOf(sel) && cycles < 20000);
  endtask

  task automatic waitPulse(input int sel, output int cycles, output int highs);
    cycles = 0; highs = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!pulseOf(sel) && outsOf(sel)[0]) highs++;
    end while (!pulseOf(sel) && cycles < 20000);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, hi, aHi, aLo;
    applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_A", {busA.period_start, busA.uio_out, busA.uo_out}, 17'd0);
    checkOutput("reset_B", {busB.period_start, busB.uio_out, busB.uo_out}, 17'd0);

    applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h80);
    rst_n = 1'b1;
    waitPulse(0, cyc, hi);
    checkOutput("A_firstPulseDelay", cyc, 256 * DIV_A + 1);
    checkOutput("A_firstPeriodHighs", hi, 0);

    runPeriod(0, -1, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("A_period", cyc, 256 * DIV_A);
    checkOutput("A_duty80_high", hi, 128 * DIV_A);

    applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h40);
    runPeriod(0, -1, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("A_duty80_kept", hi, 128 * DIV_A);
    runPeriod(0, 100 * DIV_A, 8'hC0, cyc, hi, aHi, aLo);
    checkOutput("A_duty40_midChange", hi, 64 * DIV_A);
    runPeriod(0, -1, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("A_dutyC0_high", hi, 192 * DIV_A);

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    runPeriod(0, -1, 8'h00, cyc, hi, aHi, aLo);
    runPeriod(0, 500, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("A_dutyFF_allHigh", aHi, 256 * DIV_A);
    runPeriod(0, -1, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("A_duty00_allLow", aLo, 256 * DIV_A);

    applyStimulus(8'h00, 8'hA5, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("A_uioStatic", busA.uio_out, 8'hA5);
    checkOutput("B_uioStatic", busB.uio_out, 8'hA5);
    applyStimulus(8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
    @(negedge clk);
    checkOutput("A_uioDisabled", busA.uio_out, 8'h00);

    applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h01);
    waitPulse(1, cyc, hi);
    waitPulse(1, cyc, hi);
    checkOutput("B_dutyOneAtPulse", busB.uo_out[0], 1'b1);
    runPeriod(1, -1, 8'h00, cyc, hi, aHi, aLo);
    checkOutput("B_period", cyc, 256);
    checkOutput("B_dutyOneHighs", hi, 1);

    for (int n = 0; n < 500; n++) begin
      logic [7:0] d;
      repeat ($urandom_range(1, 40)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), d);
    end

    applyStimulus(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80);
    waitPulse(0, cyc, hi);
    repeat (50 * DIV_A) @(negedge clk);
    checkOutput("A_highBeforeReset", {busA.uio_out, busA.uo_out}, 16'hFFFF);
    scoreOn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("A_asyncResetClears", {busA.period_start, busA.uio_out, busA.uo_out}, 17'd0);
    checkOutput("B_asyncResetClears", {busB.period_start, busB.uio_out, busB.uo_out}, 17'd0);
    @(negedge clk);
    scoreOn = 1'b1;
    applyStimulus(8'h01, 8'h00, 8'h01, 8'h00, 8'h80);
    rst_n = 1'b1;
    waitPulse(0, cyc, hi);
    checkOutput("A_postResetPulseDelay", cyc, 256 * DIV_A + 1);
    checkOutput("A_postResetLow", hi, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
